multicycle_ctrl: RTL and testbench

- Multicycle control FSM for the LEGv8 datapath. Handles the same instruction subset the immediate sign-extender decodes (LDUR, STUR, CBZ) plus R-type ADD/SUB/AND/ORR.
- Sequences fetch, decode, execute, memory and write-back over several cycles.
- Shares one unified instruction/data memory port through a req/ack handshake.
- Drives all datapath enables and selects, counts retired instructions, and traps on illegal opcodes or memory timeouts.

---
 rtl/multicycle_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle LEGv8 control FSM with shared memory handshake
module multicycle_ctrl #(
    parameter int MEM_WAIT_MAX = 15,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [10:0]      opcode,
    input  logic             zero,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             reg2loc,
    output logic             alu_src,
    output logic [3:0]       alu_ctl,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic [CNT_W-1:0] instr_count,
    output logic             fault,
    output logic             busy
);

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_ORR  = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_PASS = 4'b0111;

    localparam logic [7:0]       WAIT_LAST = 8'(MEM_WAIT_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_ADDR, S_MEM_RD, S_MEM_WR,
        S_WB_LD, S_EXEC_R, S_WB_R, S_BRANCH, S_FAULT
    } state_t;

    typedef enum logic [2:0] {
        K_LDUR, K_STUR, K_CBZ, K_RTYPE, K_ILLEGAL
    } kind_t;

    state_t           state_q, state_d;
    kind_t            kind_q, kind_d, dec_kind;
    logic [3:0]       alu_q, alu_d, dec_alu;
    logic [7:0]       wait_q, wait_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             retire;
    logic             req_state;

    always_comb begin
        dec_kind = K_ILLEGAL;
        dec_alu  = ALU_ADD;
        casez (opcode)
            11'b111_1100_0010: dec_kind = K_LDUR;
            11'b111_1100_0000: dec_kind = K_STUR;
            11'b101_1010_0???: dec_kind = K_CBZ;
            11'b100_0101_1000: begin dec_kind = K_RTYPE; dec_alu = ALU_ADD; end
            11'b110_0101_1000: begin dec_kind = K_RTYPE; dec_alu = ALU_SUB; end
            11'b100_0101_0000: begin dec_kind = K_RTYPE; dec_alu = ALU_AND; end
            11'b101_0101_0000: begin dec_kind = K_RTYPE; dec_alu = ALU_ORR; end
            default:           dec_kind = K_ILLEGAL;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        alu_d      = alu_q;
        wait_d     = 8'd0;
        retire     = 1'b0;
        req_state  = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        reg2loc    = 1'b0;
        alu_src    = 1'b0;
        alu_ctl    = 4'b0000;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        fault      = 1'b0;
        busy       = 1'b1;

        case (state_q)
            S_FETCH: begin
                req_state = 1'b1;
                mem_req   = 1'b1;
                if (mem_ack) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                kind_d  = dec_kind;
                alu_d   = dec_alu;
                reg2loc = (dec_kind == K_STUR) || (dec_kind == K_CBZ);
                case (dec_kind)
                    K_LDUR, K_STUR: state_d = S_ADDR;
                    K_CBZ:          state_d = S_BRANCH;
                    K_RTYPE:        state_d = S_EXEC_R;
                    default:        state_d = S_FAULT;
                endcase
            end
            S_ADDR: begin
                alu_src = 1'b1;
                alu_ctl = ALU_ADD;
                state_d = (kind_q == K_LDUR) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                req_state = 1'b1;
                mem_req   = 1'b1;
                iord      = 1'b1;
                if (mem_ack) state_d = S_WB_LD;
            end
            S_MEM_WR: begin
                req_state = 1'b1;
                mem_req   = 1'b1;
                iord      = 1'b1;
                mem_we    = 1'b1;
                reg2loc   = 1'b1;
                if (mem_ack) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_WB_LD: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_EXEC_R: begin
                alu_ctl = alu_q;
                state_d = S_WB_R;
            end
            S_WB_R: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                reg2loc = 1'b1;
                alu_ctl = ALU_PASS;
                if (zero) begin
                    pc_write = 1'b1;
                    pc_src   = 1'b1;
                end
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_FAULT: begin
                fault = 1'b1;
                busy  = 1'b0;
            end
            default: state_d = S_FAULT;
        endcase

        // An ack in the final allowed wait cycle beats the timeout.
        if (req_state && !mem_ack) begin
            if (wait_q == WAIT_LAST) state_d = S_FAULT;
            else                     wait_d  = wait_q + 8'd1;
        end

        cnt_d = retire ? cnt_q + CNT_ONE : cnt_q;

        // Outputs drop in the same cycle reset asserts, even mid-access.
        if (!reset) begin
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            iord       = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            pc_src     = 1'b0;
            reg2loc    = 1'b0;
            alu_src    = 1'b0;
            alu_ctl    = 4'b0000;
            reg_write  = 1'b0;
            mem_to_reg = 1'b0;
            fault      = 1'b0;
            busy       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            kind_q  <= K_ILLEGAL;
            alu_q   <= 4'b0000;
            wait_q  <= 8'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            alu_q   <= alu_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
        end
    end

    assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed vector bench for multicycle_ctrl
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] opcode;
    logic        zero;
    logic        mem_ack;
    logic        mem_req, mem_we, iord, ir_write, pc_write, pc_src;
    logic        reg2loc, alu_src, reg_write, mem_to_reg, fault, busy;
    logic [3:0]  alu_ctl;
    logic [31:0] instr_count;

    int errors = 0;
    int checks = 0;

    multicycle_ctrl #(.MEM_WAIT_MAX(4), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .reg2loc(reg2loc), .alu_src(alu_src),
        .alu_ctl(alu_ctl), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .instr_count(instr_count), .fault(fault), .busy(busy)
    );

    always #5 clk = ~clk;

    // {req, we, iord, irw, pcw, pcs, r2l, asrc, ctl[3:0], rw, m2r, busy}
    localparam logic [14:0] E_F1   = 15'b1_0_0_1_1_0_0_0_0000_0_0_1;
    localparam logic [14:0] E_F0   = 15'b1_0_0_0_0_0_0_0_0000_0_0_1;
    localparam logic [14:0] E_D0   = 15'b0_0_0_0_0_0_0_0_0000_0_0_1;
    localparam logic [14:0] E_D1   = 15'b0_0_0_0_0_0_1_0_0000_0_0_1;
    localparam logic [14:0] E_ADDR = 15'b0_0_0_0_0_0_0_1_0010_0_0_1;
    localparam logic [14:0] E_XADD = 15'b0_0_0_0_0_0_0_0_0010_0_0_1;
    localparam logic [14:0] E_XSUB = 15'b0_0_0_0_0_0_0_0_0110_0_0_1;
    localparam logic [14:0] E_XAND = 15'b0_0_0_0_0_0_0_0_0000_0_0_1;
    localparam logic [14:0] E_XORR = 15'b0_0_0_0_0_0_0_0_0001_0_0_1;
    localparam logic [14:0] E_WBR  = 15'b0_0_0_0_0_0_0_0_0000_1_0_1;
    localparam logic [14:0] E_MRD  = 15'b1_0_1_0_0_0_0_0_0000_0_0_1;
    localparam logic [14:0] E_WBL  = 15'b0_0_0_0_0_0_0_0_0000_1_1_1;
    localparam logic [14:0] E_MWR  = 15'b1_1_1_0_0_0_1_0_0000_0_0_1;
    localparam logic [14:0] E_BR1  = 15'b0_0_0_0_1_1_1_0_0111_0_0_1;
    localparam logic [14:0] E_BR0  = 15'b0_0_0_0_0_0_1_0_0111_0_0_1;

    localparam logic [10:0] OP_LDUR = 11'h7C2;
    localparam logic [10:0] OP_STUR = 11'h7C0;
    localparam logic [10:0] OP_CBZ  = 11'h5A3;
    localparam logic [10:0] OP_ADD  = 11'h458;
    localparam logic [10:0] OP_SUB  = 11'h658;
    localparam logic [10:0] OP_AND  = 11'h450;
    localparam logic [10:0] OP_ORR  = 11'h550;

    typedef struct {
        logic [10:0] op;
        logic        z;
        logic        ack;
        logic [14:0] exp;
        logic [31:0] cnt;
    } row_t;

    row_t vec[$];

    function automatic row_t mk(input logic [10:0] op, input logic z, input logic ack,
                                input logic [14:0] exp, input logic [31:0] cnt);
        row_t r;
        r.op = op; r.z = z; r.ack = ack; r.exp = exp; r.cnt = cnt;
        return r;
    endfunction

    function automatic logic [14:0] outs();
        return {mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg2loc, alu_src,
                alu_ctl, reg_write, mem_to_reg, busy};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; opcode = 11'h0; zero = 1'b0; mem_ack = 1'b0;

        vec.push_back(mk(OP_ADD, 0, 1, E_F1,   0));
        vec.push_back(mk(OP_ADD, 0, 0, E_D0,   0));
        vec.push_back(mk(OP_ADD, 0, 1, E_XADD, 0));
        vec.push_back(mk(OP_ADD, 0, 0, E_WBR,  0));
        vec.push_back(mk(OP_LDUR, 0, 1, E_F1,  1));
        vec.push_back(mk(OP_LDUR, 0, 0, E_D0,  1));
        vec.push_back(mk(OP_LDUR, 0, 0, E_ADDR, 1));
        vec.push_back(mk(OP_LDUR, 0, 0, E_MRD, 1));
        vec.push_back(mk(OP_LDUR, 0, 0, E_MRD, 1));
        vec.push_back(mk(OP_LDUR, 0, 0, E_MRD, 1));
        vec.push_back(mk(OP_LDUR, 0, 1, E_MRD, 1));
        vec.push_back(mk(OP_LDUR, 0, 0, E_WBL, 1));
        vec.push_back(mk(OP_STUR, 0, 0, E_F0,  2));
        vec.push_back(mk(OP_STUR, 0, 1, E_F1,  2));
        vec.push_back(mk(OP_STUR, 0, 0, E_D1,  2));
        vec.push_back(mk(OP_STUR, 0, 0, E_ADDR, 2));
        vec.push_back(mk(OP_STUR, 0, 0, E_MWR, 2));
        vec.push_back(mk(OP_STUR, 0, 1, E_MWR, 2));
        vec.push_back(mk(OP_CBZ, 1, 1, E_F1,   3));
        vec.push_back(mk(OP_CBZ, 1, 0, E_D1,   3));
        vec.push_back(mk(OP_CBZ, 1, 0, E_BR1,  3));
        vec.push_back(mk(OP_CBZ, 0, 1, E_F1,   4));
        vec.push_back(mk(OP_CBZ, 0, 0, E_D1,   4));
        vec.push_back(mk(OP_CBZ, 0, 0, E_BR0,  4));
        vec.push_back(mk(OP_SUB, 0, 1, E_F1,   5));
        vec.push_back(mk(OP_SUB, 0, 0, E_D0,   5));
        vec.push_back(mk(OP_SUB, 0, 0, E_XSUB, 5));
        vec.push_back(mk(OP_SUB, 0, 0, E_WBR,  5));
        vec.push_back(mk(OP_AND, 0, 1, E_F1,   6));
        vec.push_back(mk(OP_AND, 0, 0, E_D0,   6));
        vec.push_back(mk(OP_AND, 0, 0, E_XAND, 6));
        vec.push_back(mk(OP_AND, 0, 0, E_WBR,  6));
        vec.push_back(mk(OP_ORR, 0, 1, E_F1,   7));
        vec.push_back(mk(OP_ORR, 0, 0, E_D0,   7));
        vec.push_back(mk(OP_ORR, 0, 0, E_XORR, 7));
        vec.push_back(mk(OP_ORR, 0, 0, E_WBR,  7));
        vec.push_back(mk(OP_ADD, 0, 0, E_F0,   8));

        step();
        @(negedge clk);
        chk("reset_outs", {49'd0, outs()}, 64'd0);
        chk("reset_fault_cnt", {31'd0, fault, instr_count}, 64'd0);
        step();
        reset = 1'b1;

        for (int i = 0; i < vec.size(); i++) begin
            opcode = vec[i].op; zero = vec[i].z; mem_ack = vec[i].ack;
            @(negedge clk);
            chk($sformatf("row%0d", i), {16'd0, fault, outs(), instr_count},
                {16'd0, 1'b0, vec[i].exp, vec[i].cnt});
            step();
        end

        // Reset asserted mid-MEM_RD
        opcode = OP_LDUR; mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        step();
        step();
        @(negedge clk);
        chk("mem_rd_before_reset", {61'd0, mem_req, iord, mem_we}, {61'd0, 3'b110});
        #2 reset = 1'b0;
        #1;
        chk("mid_reset_req", {63'd0, mem_req}, 64'd0);
        chk("mid_reset_cnt_fault", {31'd0, fault, instr_count}, 64'd0);
        chk("mid_reset_busy", {63'd0, busy}, 64'd0);
        step();
        reset = 1'b1;
        #1;
        chk("post_reset_fetch", {61'd0, mem_req, iord, mem_we}, {61'd0, 3'b100});

        // One CBZ to make the count nonzero, then an illegal opcode
        opcode = OP_CBZ; zero = 1'b0; mem_ack = 1'b1;
        step(); step(); step();
        opcode = 11'h000;
        @(negedge clk);
        chk("illegal_fetch", {31'd0, ir_write, instr_count}, {31'd0, 1'b1, 32'd1});
        step();
        mem_ack = 1'b0;
        @(negedge clk);
        chk("illegal_decode", {62'd0, busy, fault}, {62'd0, 2'b10});
        step();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("fault_hold%0d", i),
                {28'd0, fault, busy, mem_req, ir_write, instr_count},
                {28'd0, 4'b1000, 32'd1});
            step();
            mem_ack = ~mem_ack;
        end

        // Fetch timeout with MEM_WAIT_MAX=4
        mem_ack = 1'b0; opcode = OP_ADD;
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk($sformatf("to_wait%0d", i), {62'd0, mem_req, fault}, {62'd0, 2'b10});
            step();
        end
        @(negedge clk);
        chk("to_fault", {61'd0, fault, mem_req, busy}, {61'd0, 3'b100});

        // Ack in the 4th request cycle wins over the timeout
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            mem_ack = (i == 4);
            @(negedge clk);
            chk($sformatf("ack_wait%0d", i), {62'd0, mem_req, fault}, {62'd0, 2'b10});
            step();
        end
        mem_ack = 1'b0;
        @(negedge clk);
        chk("ack_late_decode", {61'd0, fault, mem_req, busy}, {61'd0, 3'b001});
        step();
        @(negedge clk);
        chk("ack_late_exec", {60'd0, alu_ctl}, {60'd0, 4'b0010});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
